// File: rtl/parallel_next_state_pipe.sv
// ---------------------------------------------------------------------------
// parallel_next_state_pipe
//   Two-stage Game-of-Life row engine. Each accepted row set (top/middle/
//   bottom) produces one next-state row and one BRAM write two edges later.
//   The birth/survive rule and the horizontal edge mode are runtime
//   configurable and are latched on frame_start. The block also counts
//   completed generations and reports whether any cell changed in a frame.
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   top_row           row above the current row
//   middle_row        current row
//   bottom_row        row below the current row
//   in_row            address of middle_row
//   in_valid          row set valid
//   frame_start       pulse: latch birth_mask/survive_mask/wrap_mode
//   birth_mask        bit n: dead cell with n neighbours is born
//   survive_mask      bit n: live cell with n neighbours survives
//   wrap_mode         0 = dead border, 1 = toroidal horizontal wrap
//   result            next-state row (BRAM write data)
//   write_addr        BRAM write address
//   write_en          BRAM write enable, one cycle per row
//   frame_done        pulse with the write of the last row of a frame
//   frame_changed     any cell changed in the frame (valid with frame_done)
//   gen_count         completed generations
//   addr_err          sticky: an out-of-range in_row was received
// ---------------------------------------------------------------------------
module parallel_next_state_pipe #(
    parameter int ROW_LENGTH = 1280,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_ROWS   = 720,
    parameter int GEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROW_LENGTH-1:0] top_row,
    input  logic [ROW_LENGTH-1:0] middle_row,
    input  logic [ROW_LENGTH-1:0] bottom_row,
    input  logic [ADDR_WIDTH-1:0] in_row,
    input  logic                  in_valid,
    input  logic                  frame_start,
    input  logic [8:0]            birth_mask,
    input  logic [8:0]            survive_mask,
    input  logic                  wrap_mode,
    output logic [ROW_LENGTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_en,
    output logic                  frame_done,
    output logic                  frame_changed,
    output logic [GEN_WIDTH-1:0]  gen_count,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

    // Configuration registers (default B3/S23, dead border)
    logic [8:0] cfg_birth;
    logic [8:0] cfg_survive;
    logic       cfg_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_birth   <= 9'h008;
            cfg_survive <= 9'h00C;
            cfg_wrap    <= 1'b0;
        end else if (frame_start) begin
            cfg_birth   <= birth_mask;
            cfg_survive <= survive_mask;
            cfg_wrap    <= wrap_mode;
        end
    end

    // A row sampled on the frame_start edge must already see the new rule,
    // so the snapshot bypasses the config registers on that edge.
    logic [8:0] eff_birth;
    logic [8:0] eff_survive;
    logic       eff_wrap;

    assign eff_birth   = frame_start ? birth_mask   : cfg_birth;
    assign eff_survive = frame_start ? survive_mask : cfg_survive;
    assign eff_wrap    = frame_start ? wrap_mode    : cfg_wrap;

    // Stage 1
    logic                  v1;
    logic [ROW_LENGTH-1:0] s1_top;
    logic [ROW_LENGTH-1:0] s1_mid;
    logic [ROW_LENGTH-1:0] s1_bot;
    logic [ADDR_WIDTH-1:0] s1_row;
    logic [8:0]            s1_birth;
    logic [8:0]            s1_survive;
    logic                  s1_wrap;
    logic                  row_ok;

    assign row_ok = (in_row <= LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            v1 <= in_valid && row_ok;
            if (in_valid && !row_ok) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Data path registers need no reset: v1 qualifies everything downstream.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_top     <= top_row;
            s1_mid     <= middle_row;
            s1_bot     <= bottom_row;
            s1_row     <= in_row;
            s1_birth   <= eff_birth;
            s1_survive <= eff_survive;
            s1_wrap    <= eff_wrap;
        end
    end

    // Rows padded with one column on each side: ext[0] is column -1 and
    // ext[ROW_LENGTH+1] is column ROW_LENGTH, so cell i sees ext[i..i+2].
    logic [ROW_LENGTH+1:0] ext_top;
    logic [ROW_LENGTH+1:0] ext_mid;
    logic [ROW_LENGTH+1:0] ext_bot;

    assign ext_top = {s1_wrap & s1_top[0], s1_top, s1_wrap & s1_top[ROW_LENGTH-1]};
    assign ext_mid = {s1_wrap & s1_mid[0], s1_mid, s1_wrap & s1_mid[ROW_LENGTH-1]};
    assign ext_bot = {s1_wrap & s1_bot[0], s1_bot, s1_wrap & s1_bot[ROW_LENGTH-1]};

    logic [ROW_LENGTH-1:0] next_row;

    for (genvar i = 0; i < ROW_LENGTH; i++) begin : g_cell
        logic [3:0] cnt;
        assign cnt = {3'b000, ext_top[i]} + {3'b000, ext_top[i+1]} + {3'b000, ext_top[i+2]}
                   + {3'b000, ext_mid[i]}                          + {3'b000, ext_mid[i+2]}
                   + {3'b000, ext_bot[i]} + {3'b000, ext_bot[i+1]} + {3'b000, ext_bot[i+2]};
        assign next_row[i] = ext_mid[i+1] ? s1_survive[cnt] : s1_birth[cnt];
    end

    logic row_changed;
    logic last_row;
    logic change_acc;

    assign row_changed = (next_row != s1_mid);
    assign last_row    = (s1_row == LAST_ROW);

    // Stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result        <= '0;
            write_addr    <= '0;
            write_en      <= 1'b0;
            frame_done    <= 1'b0;
            frame_changed <= 1'b0;
            gen_count     <= '0;
            change_acc    <= 1'b0;
        end else begin
            write_en   <= v1;
            frame_done <= v1 && last_row;
            if (v1) begin
                result     <= next_row;
                write_addr <= s1_row;
                if (last_row) begin
                    frame_changed <= change_acc | row_changed;
                    change_acc    <= 1'b0;
                    gen_count     <= gen_count + GEN_WIDTH'(1);
                end else begin
                    change_acc <= change_acc | row_changed;
                end
            end
        end
    end

endmodule

// File: tb/tb_parallel_next_state_pipe.sv
module tb_parallel_next_state_pipe;

    localparam int L  = 1280;
    localparam int AW = 10;
    localparam int N  = 720;
    localparam int GW = 16;

    logic          clk;
    logic          rst;
    logic [L-1:0]  top_row;
    logic [L-1:0]  middle_row;
    logic [L-1:0]  bottom_row;
    logic [AW-1:0] in_row;
    logic          in_valid;
    logic          frame_start;
    logic [8:0]    birth_mask;
    logic [8:0]    survive_mask;
    logic          wrap_mode;
    logic [L-1:0]  result;
    logic [AW-1:0] write_addr;
    logic          write_en;
    logic          frame_done;
    logic          frame_changed;
    logic [GW-1:0] gen_count;
    logic          addr_err;

    int errors = 0;
    int checks = 0;

    parallel_next_state_pipe #(
        .ROW_LENGTH(L), .ADDR_WIDTH(AW), .NUM_ROWS(N), .GEN_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst),
        .top_row(top_row), .middle_row(middle_row), .bottom_row(bottom_row),
        .in_row(in_row), .in_valid(in_valid), .frame_start(frame_start),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap_mode(wrap_mode),
        .result(result), .write_addr(write_addr), .write_en(write_en),
        .frame_done(frame_done), .frame_changed(frame_changed),
        .gen_count(gen_count), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [L-1:0] t, input logic [L-1:0] m,
                            input logic [L-1:0] b, input logic [AW-1:0] a);
        top_row    = t;
        middle_row = m;
        bottom_row = b;
        in_row     = a;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic set_cfg(input logic [8:0] bm, input logic [8:0] sm, input logic w);
        birth_mask   = bm;
        survive_mask = sm;
        wrap_mode    = w;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (result !== '0) begin
            errors++; $display("FAIL reset_result: got ones=%0d want 0", $countones(result));
        end
        checks++;
        if ({write_en, frame_done, frame_changed, addr_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {write_en, frame_done, frame_changed, addr_err});
        end
        checks++;
        if (write_addr !== '0 || gen_count !== '0) begin
            errors++; $display("FAIL reset_counts: got addr=%0d gen=%0d want 0 0", write_addr, gen_count);
        end
    endtask

    task automatic test_blinker();
        logic [L-1:0] t, m, b, e;
        t = '0; m = '0; b = '0; e = '0;
        m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1;
        e[6] = 1'b1;
        send_row(t, m, b, 10'd3);
        checks++;
        if (write_en !== 1'b0) begin
            errors++; $display("FAIL blink_latency: got write_en=%b want 0", write_en);
        end
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== 10'd3) begin
            errors++; $display("FAIL blink_write: got en=%b addr=%0d want 1 3", write_en, write_addr);
        end
        checks++;
        if (result !== e) begin
            errors++; $display("FAIL blink_result: got ones=%0d low=%h want ones=%0d low=%h",
                               $countones(result), result[15:0], $countones(e), e[15:0]);
        end
        tick();
        checks++;
        if (write_en !== 1'b0 || result !== e || write_addr !== 10'd3) begin
            errors++; $display("FAIL blink_hold: got en=%b addr=%0d low=%h want 0 3 %h",
                               write_en, write_addr, result[15:0], e[15:0]);
        end
        // vertical blinker turns horizontal
        t = '0; m = '0; b = '0; e = '0;
        t[6] = 1'b1; m[6] = 1'b1; b[6] = 1'b1;
        e[5] = 1'b1; e[6] = 1'b1; e[7] = 1'b1;
        send_row(t, m, b, 10'd7);
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== 10'd7 || result !== e) begin
            errors++; $display("FAIL blink_vert: got en=%b addr=%0d ones=%0d low=%h want 1 7 3 %h",
                               write_en, write_addr, $countones(result), result[15:0], e[15:0]);
        end
    endtask

    task automatic test_wrap();
        logic [L-1:0] z, m, e;
        z = '0; m = '0; e = '0;
        m[0] = 1'b1; m[1] = 1'b1; m[L-1] = 1'b1;
        set_cfg(9'h008, 9'h00C, 1'b0);
        send_row(z, m, z, 10'd11);
        tick();
        checks++;
        if (write_en !== 1'b1 || result !== '0) begin
            errors++; $display("FAIL wrap_dead: got en=%b ones=%0d want 1 0", write_en, $countones(result));
        end
        // config latched on the same edge as the row
        wrap_mode   = 1'b1;
        frame_start = 1'b1;
        send_row(z, m, z, 10'd12);
        frame_start = 1'b0;
        tick();
        e[0] = 1'b1;
        checks++;
        if (write_en !== 1'b1 || result !== e) begin
            errors++; $display("FAIL wrap_torus: got en=%b ones=%0d low=%h want 1 1 %h",
                               write_en, $countones(result), result[15:0], e[15:0]);
        end
        set_cfg(9'h008, 9'h00C, 1'b0);
    endtask

    task automatic test_rule();
        logic [L-1:0] t, z, e;
        t = '0; z = '0; e = '0;
        t[9] = 1'b1; t[10] = 1'b1; t[11] = 1'b1;
        e[10] = 1'b1;
        set_cfg(9'h048, 9'h00C, 1'b0);
        send_row(t, z, t, 10'd20);
        tick();
        checks++;
        if (result !== e) begin
            errors++; $display("FAIL rule_b36: got ones=%0d low=%h want ones=1 low=%h",
                               $countones(result), result[15:0], e[15:0]);
        end
        set_cfg(9'h008, 9'h00C, 1'b0);
        send_row(t, z, t, 10'd21);
        tick();
        checks++;
        if (result !== '0 || write_addr !== 10'd21) begin
            errors++; $display("FAIL rule_b3: got ones=%0d addr=%0d want 0 21", $countones(result), write_addr);
        end
        birth_mask = 9'h048;
        send_row(t, z, t, 10'd22);
        tick();
        checks++;
        if (result !== '0 || write_addr !== 10'd22) begin
            errors++; $display("FAIL rule_nolatch: got ones=%0d addr=%0d want 0 22", $countones(result), write_addr);
        end
        birth_mask = 9'h008;
    endtask

    task automatic run_frame(input int blink_row, input logic [GW-1:0] exp_gen, input logic exp_chg);
        logic [L-1:0] blink;
        int bad;
        blink = '0;
        blink[5] = 1'b1; blink[6] = 1'b1; blink[7] = 1'b1;
        bad = 0;
        checks++;
        if (gen_count !== exp_gen - GW'(1)) begin
            errors++; $display("FAIL frame_gen_before: got %0d want %0d", gen_count, exp_gen - GW'(1));
        end
        top_row    = '0;
        bottom_row = '0;
        for (int r = 0; r < N; r++) begin
            middle_row = (r == blink_row) ? blink : '0;
            in_row     = AW'(r);
            in_valid   = 1'b1;
            tick();
            if (r >= 1 && (write_en !== 1'b1 || write_addr !== AW'(r - 1))) bad++;
            if (frame_done !== 1'b0) bad++;
        end
        in_valid   = 1'b0;
        middle_row = '0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL frame_stream: got %0d bad cycles want 0", bad);
        end
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== AW'(N - 1) || frame_done !== 1'b1) begin
            errors++; $display("FAIL frame_last: got en=%b addr=%0d done=%b want 1 %0d 1",
                               write_en, write_addr, frame_done, N - 1);
        end
        checks++;
        if (gen_count !== exp_gen || frame_changed !== exp_chg) begin
            errors++; $display("FAIL frame_status: got gen=%0d chg=%b want %0d %b",
                               gen_count, frame_changed, exp_gen, exp_chg);
        end
        tick();
        checks++;
        if (write_en !== 1'b0 || frame_done !== 1'b0 || frame_changed !== exp_chg) begin
            errors++; $display("FAIL frame_hold: got en=%b done=%b chg=%b want 0 0 %b",
                               write_en, frame_done, frame_changed, exp_chg);
        end
    endtask

    task automatic test_frame();
        do_reset();
        run_frame(-1, 16'd1, 1'b0);
        run_frame(100, 16'd2, 1'b1);
        run_frame(-1, 16'd3, 1'b0);
    endtask

    task automatic test_bad_addr();
        logic [L-1:0] z;
        z = '0;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL bad_addr_pre: got %b want 0", addr_err);
        end
        send_row(z, z, z, AW'(N));
        checks++;
        if (addr_err !== 1'b1 || write_en !== 1'b0) begin
            errors++; $display("FAIL bad_addr_set: got err=%b en=%b want 1 0", addr_err, write_en);
        end
        tick();
        checks++;
        if (write_en !== 1'b0) begin
            errors++; $display("FAIL bad_addr_drop: got en=%b want 0", write_en);
        end
        send_row(z, z, z, 10'd4);
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== 10'd4 || addr_err !== 1'b1) begin
            errors++; $display("FAIL bad_addr_sticky: got en=%b addr=%0d err=%b want 1 4 1",
                               write_en, write_addr, addr_err);
        end
    endtask

    task automatic test_reset_midflight();
        logic [L-1:0] t, m;
        t = '0; m = '0;
        t[9] = 1'b1; t[10] = 1'b1; t[11] = 1'b1;
        m[0] = 1'b1; m[1] = 1'b1; m[L-1] = 1'b1;
        set_cfg(9'h048, 9'h00C, 1'b1);
        send_row(t, m, t, 10'd5);
        rst = 1'b1;
        #2;
        checks++;
        if (write_en !== 1'b0 || write_addr !== '0 || addr_err !== 1'b0 || gen_count !== '0 ||
            frame_done !== 1'b0 || frame_changed !== 1'b0 || result !== '0) begin
            errors++; $display("FAIL midflight_outputs: got en=%b addr=%0d err=%b gen=%0d done=%b chg=%b ones=%0d want all 0",
                               write_en, write_addr, addr_err, gen_count, frame_done, frame_changed, $countones(result));
        end
        tick();
        checks++;
        if (write_en !== 1'b0) begin
            errors++; $display("FAIL midflight_in_rst: got en=%b want 0", write_en);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (write_en !== 1'b0) begin
            errors++; $display("FAIL midflight_discard: got en=%b want 0", write_en);
        end
        // inputs still request B36 + wrap, but without frame_start the reset default applies
        send_row(t, m, t, 10'd6);
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== 10'd6 || result !== '0) begin
            errors++; $display("FAIL midflight_default_cfg: got en=%b addr=%0d ones=%0d low=%h want 1 6 0 0",
                               write_en, write_addr, $countones(result), result[15:0]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        top_row      = '0;
        middle_row   = '0;
        bottom_row   = '0;
        in_row       = '0;
        in_valid     = 1'b0;
        frame_start  = 1'b0;
        birth_mask   = 9'h008;
        survive_mask = 9'h00C;
        wrap_mode    = 1'b0;
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_blinker();
        test_wrap();
        test_rule();
        test_frame();
        test_bad_addr();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parallel_next_state_pipe.md
Name: parallel_next_state_pipe

Overview:
Parametrised, pipelined Game-of-Life row engine. It replaces the fixed-width single-cycle next-state block between line_buffer and the BRAM write port. It computes one full row per cycle from top/middle/bottom rows, using a runtime-selectable B/S rule and dead-border or toroidal horizontal edges. It generates BRAM write address/enable and tracks frame completion, generation count and frame stability.

Parameters:
ROW_LENGTH, 1280, cells per row
ADDR_WIDTH, 10, row address width
NUM_ROWS, 720, rows per frame; last valid address is NUM_ROWS-1
GEN_WIDTH, 16, generation counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
top_row  input  ROW_LENGTH  row above, from line_buffer
middle_row  input  ROW_LENGTH  current row, from line_buffer
bottom_row  input  ROW_LENGTH  row below, from line_buffer
in_row  input  ADDR_WIDTH  address of middle_row
in_valid  input  1  row set valid (line_buffer valid_set AND calc_flg)
frame_start  input  1  pulse: latch rule/mode config
birth_mask  input  9  bit n=1: dead cell with n neighbours is born
survive_mask  input  9  bit n=1: live cell with n neighbours survives
wrap_mode  input  1  0 = dead border, 1 = toroidal horizontal wrap
result  output  ROW_LENGTH  next-state row, to BRAM
write_addr  output  ADDR_WIDTH  BRAM write address
write_en  output  1  BRAM write enable, one cycle per row
frame_done  output  1  pulse coincident with write of row NUM_ROWS-1
frame_changed  output  1  valid when frame_done=1: any cell changed this frame
gen_count  output  GEN_WIDTH  completed generations
addr_err  output  1  sticky: out-of-range in_row received

Behaviour:
- Reset (async, immediate): result=0, write_addr=0, write_en=0, frame_done=0, frame_changed=0, gen_count=0, addr_err=0. Pipeline valid bits cleared, so in-flight rows are discarded and never written. Config resets to B3/S23 (birth_mask=9'h008, survive_mask=9'h00C) with wrap_mode=0. Change accumulator is cleared.
- Config: on an edge with frame_start=1, birth_mask/survive_mask/wrap_mode are latched into config registers. A row sampled on the same edge uses the new config. Changes at any other time are ignored.
- Pipeline: 2 stages, no backpressure.
  - Stage 1 (edge k): when in_valid=1, register the rows, in_row, the config snapshot and v1=1; otherwise v1=0.
  - Stage 2 (edge k+1): compute per-cell neighbour count (0..8, 4-bit) and next = live ? survive_mask[cnt] : birth_mask[cnt]. Register result, write_addr=in_row, write_en=v1.
  - write_en is therefore high for exactly the cycle after edge k+1. Back-to-back in_valid gives back-to-back writes.
  - result and write_addr hold their last values when write_en=0.
- Edges: wrap_mode=0 treats column -1 and column ROW_LENGTH as dead. wrap_mode=1 makes column 0 and column ROW_LENGTH-1 neighbours. Vertical wrap is line_buffer's responsibility.
- Cell indexing: result[i] uses bits i-1, i, i+1 of the three rows.
- Address check: in_row >= NUM_ROWS with in_valid=1 means the row is dropped (no write_en) and addr_err sets. addr_err clears only on rst.
- frame_done: asserted with write_en when write_addr == NUM_ROWS-1. On the same edge gen_count increments, wrapping at 2^GEN_WIDTH.
- Change tracking: accumulator ORs (result != stage-1 middle_row) for every written row.
  - frame_changed equals the accumulator including the final row. It is registered alongside frame_done and holds until the next frame_done.
  - The accumulator clears after frame_done.
  - Duplicate addresses are written again, and the change is counted again.
- Rows may arrive in any order. Only address NUM_ROWS-1 ends a frame.

Test Plan:
- Blinker: middle_row bits 5,6,7 set, top/bottom 0, in_row=3, in_valid 1 cycle. Expect write_en high exactly 2 edges later, write_addr=3, result bit 6 only. Repeat with top/bottom bit 6: expect result bits 5,6,7.
- Wrap: middle bits 0,1 and ROW_LENGTH-1 set, top/bottom 0. With wrap_mode=0 latched, expect result=0. With wrap_mode=1, expect bit 0 set only.
- Rule switch: frame_start with birth_mask=9'h048 (B36/HighLife). Six neighbours around a dead cell give a birth. The same stimulus under default B3/S23 gives no birth. A mask change without frame_start has no effect.
- Frame end: stream rows 0..NUM_ROWS-1 back-to-back, all-zero input. Expect NUM_ROWS consecutive writes, frame_done on the last, gen_count 0→1, frame_changed=0. Repeat with one blinker row: frame_changed=1, gen_count=2.
- Bad address: in_row=NUM_ROWS with in_valid=1. Expect no write_en and addr_err=1, which persists through subsequent valid rows.
- Reset mid-flight: assert rst one cycle after in_valid. Expect write_en never asserted for that row and all outputs 0. After deassert, the config is back to B3/S23.
